// File: rtl/stack_controller_if.sv
// ============================================================================
// Module      : stack_controller_if
// Description : Request, status and RAM-side signal bundle for stack_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stack_controller_if;
    logic       Push;
    logic       Pop;
    logic       Clear;
    logic [7:0] DataIn;
    logic [7:0] RamDataIn;
    logic       RamEnable;
    logic       RamWriteEnable;
    logic [7:0] RamAddress;
    logic [7:0] RamDataOut;
    logic [7:0] Top;
    logic [8:0] Count;
    logic       Empty;
    logic       Full;
    logic       Ready;
    logic       Overflow;
    logic       Underflow;

    // The controller answers stack requests and owns the RAM port.
    modport slave (
        input  Push, Pop, Clear, DataIn, RamDataIn,
        output RamEnable, RamWriteEnable, RamAddress, RamDataOut,
        output Top, Count, Empty, Full, Ready, Overflow, Underflow
    );

    modport master (
        output Push, Pop, Clear, DataIn, RamDataIn,
        input  RamEnable, RamWriteEnable, RamAddress, RamDataOut,
        input  Top, Count, Empty, Full, Ready, Overflow, Underflow
    );
endinterface

`default_nettype wire

// File: rtl/stack_controller.sv
// ============================================================================
// Module      : stack_controller
// Description : 256-entry LIFO controller over an external 1-cycle-latency RAM.
//               Optional sticky error flags: define STACK_ERROR_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_controller (
    input  wire logic              Clk,
    input  wire logic              ResetN,
    stack_controller_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] count_q, count_d;
    logic [7:0] top_q, top_d;
    logic [7:0] hold_q, hold_d;
    logic       ram_en_q, ram_en_d;
    logic       ram_we_q, ram_we_d;
    logic [7:0] ram_addr_q, ram_addr_d;
    logic [7:0] ram_wdata_q, ram_wdata_d;

    logic w_empty, w_full;
    logic w_push_only, w_pop_only, w_clear_only;

    assign w_empty      = (count_q == 9'd0);
    assign w_full       = (count_q == 9'd256);
    assign w_push_only  =  bus.Push & ~bus.Pop & ~bus.Clear;
    assign w_pop_only   = ~bus.Push &  bus.Pop & ~bus.Clear;
    assign w_clear_only = ~bus.Push & ~bus.Pop &  bus.Clear;

    // RAM-side outputs are computed one cycle ahead so they are registered
    // for the whole WRITE/READ/LATCH cycle and zero everywhere else.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        top_d       = top_q;
        hold_d      = hold_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = 8'd0;
        ram_wdata_d = 8'd0;

        case (state_q)
            IDLE: begin
                if (w_push_only && !w_full) begin
                    hold_d      = bus.DataIn;
                    state_d     = WRITE;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = count_q[7:0];
                    ram_wdata_d = bus.DataIn;
                end else if (w_pop_only && !w_empty) begin
                    state_d = READ;
                    // Popping the last entry needs no RAM read.
                    if (count_q != 9'd1) begin
                        ram_en_d   = 1'b1;
                        ram_addr_d = count_q[7:0] - 8'd2;
                    end
                end else if (w_clear_only) begin
                    count_d = 9'd0;
                    top_d   = 8'd0;
                end
            end

            WRITE: begin
                count_d = count_q + 9'd1;
                top_d   = hold_q;
                state_d = IDLE;
            end

            READ: begin
                count_d = count_q - 9'd1;
                if (count_q == 9'd1) begin
                    top_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    state_d    = LATCH;
                    ram_en_d   = 1'b1;
                    ram_addr_d = ram_addr_q;
                end
            end

            LATCH: begin
                top_d   = bus.RamDataIn;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            count_q     <= 9'd0;
            top_q       <= 8'd0;
            hold_q      <= 8'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 8'd0;
            ram_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            top_q       <= top_d;
            hold_q      <= hold_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

`ifdef STACK_ERROR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (state_q == IDLE) begin
            if (w_push_only && w_full)  ovf_d = 1'b1;
            if (w_pop_only  && w_empty) unf_d = 1'b1;
            if (w_clear_only) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.Overflow  = ovf_q;
    assign bus.Underflow = unf_q;
`else
    assign bus.Overflow  = 1'b0;
    assign bus.Underflow = 1'b0;
`endif

    assign bus.RamEnable      = ram_en_q;
    assign bus.RamWriteEnable = ram_we_q;
    assign bus.RamAddress     = ram_addr_q;
    assign bus.RamDataOut     = ram_wdata_q;
    assign bus.Top            = top_q;
    assign bus.Count          = count_q;
    assign bus.Empty          = w_empty;
    assign bus.Full           = w_full;
    assign bus.Ready          = (state_q == IDLE);

endmodule

`default_nettype wire

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
- Clk  input  1  sole clock; all state updates on rising edge.
- ResetN  input  1  asynchronous active-low reset.
- Push  input  1  push request, sampled only while Ready=1.
- Pop  input  1  pop request, sampled only while Ready=1.
- Clear  input  1  empty the stack, sampled only while Ready=1.
- DataIn  input  8  value to push.
- RamDataIn  input  8  registered read data returned by the RAM, 1-cycle latency.
- RamEnable  output  1  RAM access enable.
- RamWriteEnable  output  1  RAM write strobe.
- RamAddress  output  8  RAM address.
- RamDataOut  output  8  RAM write data.
- Top  output  8  current top-of-stack value; 0 when empty.
- Count  output  9  number of stored entries, 0..256.
- Empty  output  1  Count==0.
- Full  output  1  Count==256.
- Ready  output  1  high in IDLE only.
- Overflow  output  1  sticky push-while-full flag.
- Underflow  output  1  sticky pop-while-empty flag.

Function
REQ-002 SHALL implement a state machine with states IDLE, WRITE, READ and LATCH.
REQ-003 In IDLE with exactly one of Push, Pop or Clear high, SHALL act on it; with two or more high, SHALL ignore all of them and remain in IDLE.
REQ-004 On Push in IDLE with Full=0, SHALL register DataIn into a hold register and go to WRITE.
REQ-005 In WRITE, SHALL drive RamEnable=1, RamWriteEnable=1, RamAddress=Count[7:0], RamDataOut=hold; at that edge SHALL set Count+1 and Top=hold, then return to IDLE (push = 2 cycles).
REQ-006 On Pop in IDLE with Empty=0, SHALL go to READ, which sets Count-1 at the edge leaving READ.
REQ-007 In READ, if new Count==0, SHALL set Top=0, perform no RAM access and return to IDLE.
REQ-008 In READ, otherwise, SHALL drive RamEnable=1, RamWriteEnable=0, RamAddress=Count-2 (the new top) and go to LATCH.
REQ-009 In LATCH, SHALL keep RamEnable=1 with the same address, capture RamDataIn into Top, and return to IDLE (pop = 2 or 3 cycles).
REQ-010 On Clear in IDLE, SHALL set Count=0 and Top=0 in one cycle, stay in IDLE, and leave RAM contents untouched.
REQ-011 Push while Full=1 or Pop while Empty=1 SHALL be ignored with no state, Count or Top change.
REQ-012 Outside WRITE/READ/LATCH, RamEnable, RamWriteEnable, RamAddress and RamDataOut SHALL be 0.
REQ-013 Empty, Full and Ready SHALL be combinational decodes of registered state; all other outputs SHALL be registered or constant per state.
REQ-014 Count SHALL never wrap: 256 is the maximum and 0 the minimum.

Reset
REQ-015 ResetN=0 SHALL immediately force IDLE, Count=0, Top=0, hold=0, Overflow=0 and Underflow=0, with all RAM-side outputs 0, including mid-WRITE/READ/LATCH.
REQ-016 Reset SHALL NOT clear RAM contents; the first Push after reset SHALL write address 0.

Configuration
REQ-017 Macro STACK_ERROR_FLAGS_EN, when defined, SHALL make Overflow set on an ignored Push while Full=1 and Underflow set on an ignored Pop while Empty=1; both SHALL stay set until reset or Clear.
REQ-018 When STACK_ERROR_FLAGS_EN is undefined, Overflow and Underflow SHALL be constant 0 and no flag registers SHALL exist.

Verification
REQ-019 Bench SHALL pair the block with the RAMUnit model and cover:
- Reset, then Push 0x11, 0x22, 0x33 -> Count=3, Top=0x33, RAM[0..2]=0x11, 0x22, 0x33.
- Pop twice from the above -> Top=0x22, then 0x11; Count=1; third Pop -> Top=0x00, Empty=1, no RAM read.
- Push 256 values i=0..255 -> Full=1, Top=0xFF; 257th Push ignored, Count=256, Overflow=1 only with STACK_ERROR_FLAGS_EN.
- Push and Pop high together in IDLE -> no change; Pop on empty -> Underflow per macro.
- ResetN pulsed low during LATCH after 5 pushes -> Count=0, Top=0, Ready=1 immediately; next Push 0xAA writes RAM[0].
- Clear with Count=4 -> Count=0, Top=0, flags cleared, Ready stays 1.
